// File: rtl/mmio_ddfs_pkg.sv
// Shared definitions for the multi-channel DDFS MMIO slot:
// register map, ctrl/status bit positions and frame sequencer states.
package mmio_ddfs_pkg;

  localparam int CH_MAX = 4;
  localparam int MIX_W  = 18;

  localparam logic [4:0] A_CTRL = 5'h10;
  localparam logic [4:0] A_STAT = 5'h11;
  localparam logic [4:0] A_PCM  = 5'h12;

  localparam logic [1:0] R_FCCW = 2'd0;
  localparam logic [1:0] R_FOCW = 2'd1;
  localparam logic [1:0] R_PHA  = 2'd2;
  localparam logic [1:0] R_AMP  = 2'd3;

  localparam int CTRL_CLR_LSB = 8;
  localparam int ST_BUSY      = 0;
  localparam int ST_OVR       = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/ddfs_sin_rom.sv
// One-period sine table, +/-32767 full scale, registered output.
// Contents are computed at elaboration with a range-reduced series.
module ddfs_sin_rom
  import mmio_ddfs_pkg::*;
#(
  parameter int LW = 10
) (
  input  logic                 clk,
  input  logic [LW-1:0]        addr,
  output logic signed [15:0]   data
);

  localparam int  N  = 1 << LW;
  localparam real PI = 3.14159265358979323846;

  function automatic logic signed [15:0] sin_q15(input int i);
    real x, x2, t, s, r;
    x = 2.0 * PI * real'(i) / real'(N);
    if (x > PI) x = x - 2.0 * PI;
    // Fold into [-pi/2, pi/2] so the series converges fast
    if (x > PI / 2.0) x = PI - x;
    else if (x < -PI / 2.0) x = -PI - x;
    x2 = x * x;
    t  = x;
    s  = x;
    for (int k = 1; k < 10; k++) begin
      t = -t * x2 / real'((2 * k) * (2 * k + 1));
      s = s + t;
    end
    r = s * 32767.0;
    r = (r >= 0.0) ? r + 0.5 : r - 0.5;
    return 16'($rtoi(r));
  endfunction

  logic signed [15:0] tbl [N];

  for (genvar i = 0; i < N; i++) begin : g_tbl
    assign tbl[i] = sin_q15(i);
  end

  always_ff @(posedge clk) data <= tbl[addr];

endmodule

// File: rtl/mmio_ddfs_mc.sv
// Multi-channel DDFS: per-channel registers and accumulators feeding
// one shared issue/ROM/multiply/mix pipeline once per sample tick.
module mmio_ddfs_mc
  import mmio_ddfs_pkg::*;
#(
  parameter int PW = 30,
  parameter int CH = 4,
  parameter int LW = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic                write,
  input  logic                read,
  input  logic [4:0]          addr,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  input  logic                tick,
  output logic signed [15:0]  pcm_out,
  output logic                data_valid
);

  localparam logic signed [MIX_W-1:0] SMAX = MIX_W'(32767);
  localparam logic signed [MIX_W-1:0] SMIN = MIX_W'(-32768);

  logic [PW-1:0] fccw_q [CH];
  logic [PW-1:0] focw_q [CH];
  logic [PW-1:0] pha_q  [CH];
  logic [PW-1:0] acc_q  [CH];
  logic [15:0]   amp_q  [CH];
  logic [CH-1:0] en_q, clr_q, clr_set, idx_oh;
  logic          ovr_q, busy, wr, ch_ok, issue;
  state_t        state_q;
  logic [1:0]    idx_q, ch;

  logic [PW-1:0] acc_d, phase_d;
  logic          p1_v, p1_last, p1_en;
  logic [LW-1:0] p1_addr;
  logic [15:0]   p1_amp, p2_amp;
  logic          p2_v, p2_last, p2_en;
  logic          p3_v, p3_last, dv_q;
  logic signed [15:0]      sine, term_d, term_q, pcm_q, sat_d;
  logic signed [32:0]      prod;
  logic signed [MIX_W-1:0] sum_q, sum_d;
  logic                    unused_ok;

  assign wr     = cs & write;
  assign ch     = addr[3:2];
  assign ch_ok  = !addr[4] && (int'(ch) < CH);
  assign busy   = state_q != S_IDLE;
  assign issue  = state_q == S_RUN;
  assign idx_oh = issue ? (CH'(1) << idx_q) : '0;
  assign clr_set = (wr && addr == A_CTRL) ?
                   write_data[CH+CTRL_CLR_LSB-1:CTRL_CLR_LSB] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        fccw_q[c] <= '0;
        focw_q[c] <= '0;
        pha_q[c]  <= '0;
        amp_q[c]  <= '0;
      end
      en_q <= '0;
    end else if (wr) begin
      if (ch_ok) begin
        unique case (addr[1:0])
          R_FCCW: fccw_q[ch] <= write_data[PW-1:0];
          R_FOCW: focw_q[ch] <= write_data[PW-1:0];
          R_PHA:  pha_q[ch]  <= write_data[PW-1:0];
          R_AMP:  amp_q[ch]  <= write_data[15:0];
        endcase
      end else if (addr == A_CTRL) begin
        en_q <= write_data[CH-1:0];
      end
    end
  end

  // A pending clear replaces the step on the channel's next issue
  always_comb begin
    acc_d = acc_q[idx_q];
    if (clr_q[idx_q]) acc_d = '0;
    else if (en_q[idx_q]) acc_d = acc_q[idx_q] + fccw_q[idx_q];
    phase_d = acc_d + focw_q[idx_q] + pha_q[idx_q];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) acc_q[c] <= '0;
      clr_q <= '0;
    end else begin
      if (issue) acc_q[idx_q] <= acc_d;
      clr_q <= (clr_q & ~idx_oh) | clr_set;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (wr && addr == A_STAT) ovr_q <= 1'b0;
      if (tick && busy) ovr_q <= 1'b1;
      unique case (state_q)
        S_IDLE: if (tick) begin
          state_q <= S_RUN;
          idx_q   <= '0;
        end
        S_RUN: begin
          if (idx_q == 2'(CH - 1)) state_q <= S_FLUSH;
          else idx_q <= idx_q + 2'd1;
        end
        S_FLUSH: if (dv_q) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  ddfs_sin_rom #(.LW(LW)) u_rom (
    .clk  (clk),
    .addr (p1_addr),
    .data (sine)
  );

  assign prod   = sine * $signed({1'b0, p2_amp});
  assign term_d = p2_en ? prod[31:16] : '0;
  assign sum_d  = sum_q + MIX_W'(term_q);

  always_comb begin
    if (sum_d > SMAX) sat_d = 16'sh7fff;
    else if (sum_d < SMIN) sat_d = 16'sh8000;
    else sat_d = sum_d[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {p1_v, p1_last, p1_en, p1_addr, p1_amp} <= '0;
      {p2_v, p2_last, p2_en, p2_amp}          <= '0;
      {p3_v, p3_last, term_q}                 <= '0;
      sum_q <= '0;
      pcm_q <= '0;
      dv_q  <= 1'b0;
    end else begin
      p1_v    <= issue;
      p1_last <= issue && idx_q == 2'(CH - 1);
      p1_en   <= en_q[idx_q];
      p1_addr <= phase_d[PW-1:PW-LW];
      p1_amp  <= amp_q[idx_q];
      p2_v    <= p1_v;
      p2_last <= p1_last;
      p2_en   <= p1_en;
      p2_amp  <= p1_amp;
      p3_v    <= p2_v;
      p3_last <= p2_last;
      term_q  <= term_d;
      dv_q    <= 1'b0;
      if (!busy && tick) begin
        sum_q <= '0;
      end else if (p3_v) begin
        sum_q <= p3_last ? '0 : sum_d;
        if (p3_last) begin
          pcm_q <= sat_d;
          dv_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    read_data = '0;
    if (ch_ok) begin
      unique case (addr[1:0])
        R_FCCW: read_data = 32'(fccw_q[ch]);
        R_FOCW: read_data = 32'(focw_q[ch]);
        R_PHA:  read_data = 32'(pha_q[ch]);
        R_AMP:  read_data = 32'(amp_q[ch]);
      endcase
    end else if (addr == A_CTRL) begin
      read_data = 32'(en_q);
    end else if (addr == A_STAT) begin
      read_data[ST_BUSY] = busy;
      read_data[ST_OVR]  = ovr_q;
    end else if (addr == A_PCM) begin
      read_data = 32'(pcm_q);
    end
  end

  assign pcm_out    = pcm_q;
  assign data_valid = dv_q;
  assign unused_ok  = ^{read, write_data, phase_d, prod[32], prod[15:0]};

endmodule

// File: tb/tb_mmio_ddfs_mc.sv
// Randomised and directed bench for mmio_ddfs_mc against a
// frame-level arithmetic model of the synthesiser.
`timescale 1ns/1ps
module tb_mmio_ddfs_mc;

  localparam int     PW   = 30;
  localparam int     CH   = 4;
  localparam int     LW   = 10;
  localparam longint MASK = (longint'(1) << PW) - 1;
  localparam real    PI   = 3.14159265358979323846;

  logic clk = 1'b0;
  logic reset, cs, write, read, tick;
  logic [4:0]  addr;
  logic [31:0] write_data, read_data;
  logic signed [15:0] pcm_out;
  logic data_valid;

  int n_chk = 0;
  int n_err = 0;

  longint m_fccw[CH], m_focw[CH], m_pha[CH], m_amp[CH], m_acc[CH];
  bit     m_en[CH], m_pend[CH];
  longint m_pcm;

  mmio_ddfs_mc #(.PW(PW), .CH(CH), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .write      (write),
    .read       (read),
    .addr       (addr),
    .write_data (write_data),
    .read_data  (read_data),
    .tick       (tick),
    .pcm_out    (pcm_out),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int c = 0; c < CH; c++) begin
      m_fccw[c] = 0; m_focw[c] = 0; m_pha[c] = 0;
      m_amp[c] = 0;  m_acc[c] = 0;  m_en[c] = 0; m_pend[c] = 0;
    end
    m_pcm = 0;
  endtask

  task automatic mdl_wr(input logic [4:0] a, input logic [31:0] d);
    int c;
    c = int'(a[3:2]);
    if (!a[4]) begin
      if (c < CH) begin
        case (a[1:0])
          2'd0: m_fccw[c] = longint'(d) & MASK;
          2'd1: m_focw[c] = longint'(d) & MASK;
          2'd2: m_pha[c]  = longint'(d) & MASK;
          default: m_amp[c] = longint'(d) & 64'hFFFF;
        endcase
      end
    end else if (a == 5'h10) begin
      for (int k = 0; k < CH; k++) begin
        m_en[k] = d[k];
        if (d[8 + k]) m_pend[k] = 1'b1;
      end
    end
  endtask

  function automatic longint sine_ref(longint a);
    real r;
    r = 32767.0 * $sin(2.0 * PI * real'(a) / real'(1 << LW));
    r = (r >= 0.0) ? r + 0.5 : r - 0.5;
    return longint'($rtoi(r));
  endfunction

  task automatic model_frame(output longint exp);
    longint sum, ph, t;
    sum = 0;
    for (int c = 0; c < CH; c++) begin
      if (m_pend[c]) begin
        m_acc[c] = 0;
        m_pend[c] = 1'b0;
      end else if (m_en[c]) begin
        m_acc[c] = (m_acc[c] + m_fccw[c]) & MASK;
      end
      ph = (m_acc[c] + m_focw[c] + m_pha[c]) & MASK;
      t = (sine_ref(ph >> (PW - LW)) * m_amp[c]) >>> 16;
      if (m_en[c]) sum += t;
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    exp = sum;
  endtask

  task automatic mwr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; write_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
    mdl_wr(a, d);
  endtask

  task automatic mrd(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    #1 d = read_data;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    mdl_clear();
  endtask

  task automatic do_frame(input string tag);
    longint e;
    int n;
    logic [31:0] r;
    model_frame(e);
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    n = 1;
    while (!data_valid && n < 3 * CH + 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, CH + 4);
    chk({tag, "_pcm"}, pcm_out, e);
    m_pcm = e;
    @(posedge clk); #1;
    chk({tag, "_dv1"}, data_valid, 0);
    mrd(5'h11, r);
    chk({tag, "_idle"}, r, 0);
  endtask

  logic [31:0] r;
  longint e;
  int n, cnt, c;

  initial begin
    reset = 1'b1; cs = 1'b0; write = 1'b0; read = 1'b0;
    tick = 1'b0; addr = '0; write_data = '0;
    mdl_clear();
    do_reset();

    chk("rst_pcm", pcm_out, 0);
    chk("rst_dv", data_valid, 0);
    mrd(5'h10, r); chk("rst_ctrl", r, 0);
    mrd(5'h11, r); chk("rst_stat", r, 0);
    mrd(5'h12, r); chk("rst_pcmrd", r, 0);
    mrd(5'h07, r); chk("rst_amp1", r, 0);

    mwr(5'h00, 32'hFFFF_FFFF); mrd(5'h00, r); chk("rd_fccw", r, 32'h3FFF_FFFF);
    mwr(5'h07, 32'h1234_5678); mrd(5'h07, r); chk("rd_amp", r, 32'h5678);
    mwr(5'h10, 32'h0000_0F0A); mrd(5'h10, r); chk("rd_ctrl", r, 32'hA);
    mwr(5'h13, 32'hDEAD_BEEF); mrd(5'h13, r); chk("rd_hole", r, 0);
    do_reset();

    mwr(5'h02, 32'h1000_0000);
    mwr(5'h03, 32'h0000_FFFF);
    mwr(5'h10, 32'h1);
    do_frame("dc");
    chk("dc_peak", pcm_out, 32766);
    mrd(5'h12, r); chk("dc_rd", r, m_pcm & 64'hFFFF_FFFF);

    mwr(5'h00, 32'h1000_0000);
    for (int i = 0; i < 5; i++) do_frame($sformatf("acc%0d", i));

    for (int k = 0; k < CH; k++) begin
      mwr(5'(k * 4 + 0), 32'h0);
      mwr(5'(k * 4 + 2), 32'h1000_0000);
      mwr(5'(k * 4 + 3), 32'hFFFF);
    end
    mwr(5'h10, 32'h0000_0F0F);
    do_frame("sat_pos");
    chk("sat_max", pcm_out, 32767);
    for (int k = 0; k < CH; k++) mwr(5'(k * 4 + 2), 32'h3000_0000);
    do_frame("sat_neg");
    chk("sat_min", pcm_out, -32768);

    model_frame(e);
    cnt = 0;
    @(posedge clk); #1 tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tick = (i == 1);
      if (data_valid) cnt++;
    end
    chk("ovr_dv_cnt", cnt, 1);
    chk("ovr_pcm", pcm_out, e);
    mrd(5'h11, r); chk("ovr_stat", r, 2);
    mwr(5'h11, 32'h0);
    mrd(5'h11, r); chk("ovr_clr", r, 0);

    do_reset();
    mwr(5'h04, 32'h0123_4567);
    mwr(5'h05, 32'h0100_0000);
    mwr(5'h06, 32'h0200_0000);
    mwr(5'h07, 32'h0000_8000);
    mwr(5'h10, 32'h2);
    do_frame("ch1_a");
    do_frame("ch1_b");
    mwr(5'h10, 32'h0);
    do_frame("ch1_off");
    chk("ch1_off_zero", pcm_out, 0);
    mwr(5'h10, 32'h2);
    do_frame("ch1_held");
    mwr(5'h10, 32'h0000_0202);
    do_frame("ch1_clr");

    do_reset();
    mwr(5'h02, 32'h1000_0000); mwr(5'h03, 32'h0000_4000);
    mwr(5'h0E, 32'h1000_0000); mwr(5'h0F, 32'h0000_2000);
    mwr(5'h10, 32'h9);
    m_amp[3] = 64'h4000;
    model_frame(e);
    m_amp[0] = 64'hFFFF;
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    cs = 1'b1; write = 1'b1; addr = 5'h03; write_data = 32'hFFFF;
    @(posedge clk); #1 addr = 5'h0F; write_data = 32'h4000;
    @(posedge clk); #1 cs = 1'b0; write = 1'b0;
    n = 3;
    while (!data_valid && n < 3 * CH + 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("fly_lat", n, CH + 4);
    chk("fly_pcm", pcm_out, e);
    repeat (3) @(posedge clk);
    #1;

    for (int it = 0; it < 24; it++) begin
      c = $urandom_range(0, CH - 1);
      mwr(5'(c * 4 + 0), $urandom);
      mwr(5'(c * 4 + 1), $urandom);
      mwr(5'(c * 4 + 2), $urandom);
      mwr(5'(c * 4 + 3), $urandom);
      if ($urandom_range(0, 3) == 0) mwr(5'h10, $urandom & 32'h0000_0F0F);
      else mwr(5'h10, $urandom & 32'hF);
      if ($urandom_range(0, 4) == 0) mwr(5'(5'h13 + $urandom_range(0, 12)), $urandom);
      do_frame($sformatf("rnd%0d", it));
    end

    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("mid_rst_pcm_async", pcm_out, 0);
    @(posedge clk); #1 reset = 1'b0;
    mdl_clear();
    cnt = 0;
    repeat (12) begin
      if (data_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("mid_rst_dv", cnt, 0);
    chk("mid_rst_pcm", pcm_out, 0);
    mrd(5'h11, r); chk("mid_rst_stat", r, 0);
    mrd(5'h10, r); chk("mid_rst_ctrl", r, 0);
    for (int a = 0; a < 16; a++) begin
      mrd(5'(a), r);
      chk($sformatf("mid_rst_reg%0d", a), r, 0);
    end
    mwr(5'h02, 32'h3000_0000);
    mwr(5'h03, 32'h0000_C000);
    mwr(5'h10, 32'h1);
    do_frame("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
